crc_serial_gen: RTL and testbench
=================================

CRC_SERIAL_GEN -- requirements
Module: crc_serial_gen

Interface
REQ-001 Parameter CRC_W, default 8, CRC register width in bits; SHALL be legal for 2..32.
REQ-002 Parameter TAPS, default 8'h44 (CRC_W bits), feedback tap mask; bit CRC_W-1 SHALL be ignored.
REQ-003 Parameter SEED, default 8'hD8 (CRC_W bits), register value loaded at reset and at every frame start.
REQ-004 Parameter FINAL_XOR, default 0 (CRC_W bits), mask XORed onto each serialized output bit.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 DATA  input  1  serial message bit, sampled on clk while Active=1.
REQ-008 Active  input  1  frame-valid qualifier, high for exactly the message bits.
REQ-009 CRC  output  1  serial CRC bit, registered.
REQ-010 Valid  output  1  high while CRC carries a result bit, registered.
REQ-011 Busy  output  1  high in CALC or OUT state, registered.

Function
REQ-012 The block SHALL implement states IDLE, CALC and OUT, with a bit counter of clog2(CRC_W) bits.
REQ-013 IDLE: when Active=1 is sampled, the first bit SHALL be absorbed into a register loaded from SEED (r = f(SEED, DATA)); next state CALC.
REQ-014 Absorb step, with fb = DATA ^ r[0]: r[CRC_W-1] <= fb; r[i] <= r[i+1] ^ (TAPS[i] & fb) for i = 0..CRC_W-2.
REQ-015 CALC: each edge with Active=1 SHALL apply one absorb step; frame length SHALL be unbounded.
REQ-016 CALC: the first edge with Active=0 SHALL enter OUT and set Valid=1, CRC = r[0]^FINAL_XOR[0], counter=0.
REQ-017 OUT: each edge SHALL shift r right by one with zero fill and increment the counter; output bit k SHALL equal r_final[k]^FINAL_XOR[k], LSB first.
REQ-018 Valid SHALL be high for exactly CRC_W consecutive cycles per frame; after the last bit the state SHALL be IDLE with Valid=0 and CRC=0.
REQ-019 Latency: the first CRC bit SHALL appear in the cycle immediately after the last sampled message bit; there SHALL be no gap cycles.
REQ-020 Active and DATA SHALL be ignored in OUT.
REQ-021 If Active=1 is sampled on the edge that leaves OUT, the block SHALL start a new frame from SEED per REQ-013 (back-to-back frames).
REQ-022 Busy SHALL be high from the edge after the first Active=1 sample until the edge that returns to IDLE.
REQ-023 Frames with Active high for zero cycles SHALL NOT produce output.

Reset
REQ-024 RST=1 at a clk edge SHALL force IDLE, r=SEED, counter=0, CRC=0, Valid=0, Busy=0, overriding all other inputs.
REQ-025 RST asserted mid-CALC or mid-OUT SHALL abort the frame with no further Valid pulses; an Active=1 sampled on the same edge SHALL be ignored.
REQ-026 After RST deasserts, the first frame SHALL behave identically to a frame after power-up reset.

Verification (defaults CRC_W=8, TAPS=8'h44, SEED=8'hD8, FINAL_XOR=0 unless stated)
REQ-027 One-bit frame, DATA=0 -> Valid for 8 cycles; serial CRC 0,0,1,1,0,1,1,0 (value 8'h6C).
REQ-028 One-bit frame, DATA=1 -> CRC value 8'hA8; two-bit frame 1 then 0 -> 8'h54.
REQ-029 FINAL_XOR=8'hFF, one-bit frame, DATA=0 -> CRC value 8'h93.
REQ-030 SEED=0, 8-bit frame of all zeros -> CRC 8'h00; Valid starts exactly 1 cycle after the last Active cycle.
REQ-031 Back-to-back: Active reasserted on the last OUT edge -> the second frame is absorbed from SEED; two separate 8-cycle Valid windows with correct values.
REQ-032 RST pulsed during OUT bit 3 -> Valid=0 and CRC=0 on the next cycle; the following 1-bit DATA=0 frame yields 8'h6C.

Source files
------------

// File: rtl/crc_serial_gen.sv
// Bit-serial CRC generator: absorbs a framed serial message through a Galois
// shift register, then streams the CRC out LSB first with no gap cycle.
module crc_serial_gen #(
   parameter int unsigned      CRC_W     = 8,
   parameter logic [CRC_W-1:0] TAPS      = 8'h44,
   parameter logic [CRC_W-1:0] SEED      = 8'hD8,
   parameter logic [CRC_W-1:0] FINAL_XOR = 8'h00
) (
   input  logic clk,
   input  logic RST,
   input  logic DATA,
   input  logic Active,
   output logic CRC,
   output logic Valid,
   output logic Busy
);

   localparam int unsigned      CNT_W    = $clog2(CRC_W);
   // Top bit forced to 1 so the feedback bit lands in r[CRC_W-1]; TAPS[CRC_W-1] is ignored.
   localparam logic [CRC_W-1:0] FB_MASK  = {1'b1, TAPS[CRC_W-2:0]};
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_W - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CRC_W-1:0]   lfsr_r;
   logic [CRC_W-1:0]   lfsr_nxt_s;
   logic [CRC_W-1:0]   lfsr_shift_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic               crc_bit_r;
   logic               crc_bit_nxt_s;
   logic               valid_r;
   logic               valid_nxt_s;
   logic               busy_r;
   logic               busy_nxt_s;

   function automatic logic [CRC_W-1:0] absorb(input logic [CRC_W-1:0] cur,
                                               input logic             bit_in);
      logic fb;
      fb = bit_in ^ cur[0];
      return {1'b0, cur[CRC_W-1:1]} ^ (FB_MASK & {CRC_W{fb}});
   endfunction

   assign lfsr_shift_s = {1'b0, lfsr_r[CRC_W-1:1]};
   assign cnt_inc_s    = cnt_r + CNT_ONE;

   // State register
   always_ff @(posedge clk) begin
      if (RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; an Active sample on the last OUT edge chains a new frame
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (Active) state_nxt_s = CALC;
            else        state_nxt_s = IDLE;
         end
         CALC: begin
            if (Active) state_nxt_s = CALC;
            else        state_nxt_s = OUT;
         end
         OUT: begin
            if (cnt_r == LAST_BIT) begin
               if (Active) state_nxt_s = CALC;
               else        state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OUT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath and output next values; the CRC bit is pre-computed one edge early
   always_comb begin
      lfsr_nxt_s    = lfsr_r;
      cnt_nxt_s     = cnt_r;
      crc_bit_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (Active) lfsr_nxt_s = absorb(SEED, DATA);
            else        lfsr_nxt_s = lfsr_r;
         end
         CALC: begin
            if (Active) begin
               lfsr_nxt_s = absorb(lfsr_r, DATA);
            end else begin
               cnt_nxt_s     = {CNT_W{1'b0}};
               crc_bit_nxt_s = lfsr_r[0] ^ FINAL_XOR[0];
            end
         end
         OUT: begin
            if (cnt_r == LAST_BIT) begin
               cnt_nxt_s = {CNT_W{1'b0}};
               if (Active) lfsr_nxt_s = absorb(SEED, DATA);
               else        lfsr_nxt_s = lfsr_shift_s;
            end else begin
               lfsr_nxt_s    = lfsr_shift_s;
               cnt_nxt_s     = cnt_inc_s;
               crc_bit_nxt_s = lfsr_r[1] ^ FINAL_XOR[cnt_inc_s];
            end
         end
         default: begin
            lfsr_nxt_s = SEED;
            cnt_nxt_s  = {CNT_W{1'b0}};
         end
      endcase
      valid_nxt_s = (state_nxt_s == OUT);
      busy_nxt_s  = (state_nxt_s != IDLE);
   end

   // Datapath and registered outputs; reset overrides Active on the same edge
   always_ff @(posedge clk) begin
      if (RST) begin
         lfsr_r    <= SEED;
         cnt_r     <= {CNT_W{1'b0}};
         crc_bit_r <= 1'b0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         lfsr_r    <= lfsr_nxt_s;
         cnt_r     <= cnt_nxt_s;
         crc_bit_r <= crc_bit_nxt_s;
         valid_r   <= valid_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   assign CRC   = crc_bit_r;
   assign Valid = valid_r;
   assign Busy  = busy_r;

endmodule

// File: tb/tb_crc_serial_gen.sv
// Bench for crc_serial_gen: four parameterisations share one stimulus stream and
// are compared every cycle against a frame/queue-level reference model.
module tb_crc_serial_gen;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         act = 1'b0;
   logic         din = 1'b0;
   logic [N-1:0] crc_o;
   logic [N-1:0] valid_o;
   logic [N-1:0] busy_o;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   // Per-instance parameters as seen by the model
   int w_p    [N] = '{8, 8, 8, 5};
   int taps_p [N] = '{'h44, 'h44, 'h44, 'h19};
   int seed_p [N] = '{'hD8, 'hD8, 'h00, 'h13};
   int fx_p   [N] = '{'h00, 'hFF, 'h00, 'h06};

   // Model state: collected message bits, and the pending serialized result
   bit [127:0] msg  [N];
   int         mlen [N];
   bit         infr [N];
   bit         emit [N];
   int         oval [N];
   int         opos [N];
   logic [2:0] expv [N];

   // Capture of the most recent DUT Valid window
   int cap  [N];
   int cpos [N];
   bit pval [N];

   always #5 clk = ~clk;

   crc_serial_gen u_def (
      .clk(clk), .RST(rst), .DATA(din), .Active(act),
      .CRC(crc_o[0]), .Valid(valid_o[0]), .Busy(busy_o[0]));

   crc_serial_gen #(.FINAL_XOR(8'hFF)) u_fx (
      .clk(clk), .RST(rst), .DATA(din), .Active(act),
      .CRC(crc_o[1]), .Valid(valid_o[1]), .Busy(busy_o[1]));

   crc_serial_gen #(.SEED(8'h00)) u_s0 (
      .clk(clk), .RST(rst), .DATA(din), .Active(act),
      .CRC(crc_o[2]), .Valid(valid_o[2]), .Busy(busy_o[2]));

   crc_serial_gen #(.CRC_W(5), .TAPS(5'h19), .SEED(5'h13), .FINAL_XOR(5'h06)) u_w5 (
      .clk(clk), .RST(rst), .DATA(din), .Active(act),
      .CRC(crc_o[3]), .Valid(valid_o[3]), .Busy(busy_o[3]));

   function automatic int crc_of(input int i);
      int r;
      int top;
      int poly;
      int fb;
      r    = seed_p[i];
      top  = 1 << (w_p[i] - 1);
      poly = (taps_p[i] & (top - 1)) | top;
      for (int k = 0; k < mlen[i]; k++) begin
         fb = int'(msg[i][k]) ^ (r & 1);
         r  = (r >> 1) ^ (fb != 0 ? poly : 0);
      end
      return r;
   endfunction

   task automatic start_frame(input int i);
      msg[i]    = '0;
      msg[i][0] = din;
      mlen[i]   = 1;
      infr[i]   = 1'b1;
   endtask

   // Advance the model across one clock edge using the inputs presented to it
   task automatic model_step(input int i);
      if (rst) begin
         infr[i] = 1'b0;
         emit[i] = 1'b0;
      end else if (emit[i]) begin
         if (opos[i] < w_p[i] - 1) begin
            opos[i]++;
         end else begin
            emit[i] = 1'b0;
            if (act) start_frame(i);
         end
      end else if (infr[i]) begin
         if (act) begin
            msg[i][mlen[i]] = din;
            mlen[i]++;
         end else begin
            oval[i] = crc_of(i) ^ fx_p[i];
            opos[i] = 0;
            emit[i] = 1'b1;
            infr[i] = 1'b0;
         end
      end else if (act) begin
         start_frame(i);
      end
      expv[i] = {infr[i] | emit[i], emit[i], emit[i] && (((oval[i] >> opos[i]) & 1) != 0)};
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      for (int i = 0; i < N; i++) model_step(i);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         check($sformatf("inst%0d_cyc%0d_busy_valid_crc", i, cyc),
               {29'd0, busy_o[i], valid_o[i], crc_o[i]}, {29'd0, expv[i]});
         if (valid_o[i] && !pval[i]) begin
            cap[i]  = 0;
            cpos[i] = 0;
         end
         if (valid_o[i]) begin
            cap[i] = cap[i] | (int'(crc_o[i]) << cpos[i]);
            cpos[i]++;
         end
         pval[i] = valid_o[i];
      end
   endtask

   task automatic frame(input logic [31:0] bits, input int len, input int idle);
      for (int k = 0; k < len; k++) begin
         act = 1'b1;
         din = bits[k];
         tick();
      end
      act = 1'b0;
      din = 1'b0;
      repeat (idle) tick();
   endtask

   initial begin
      // Reset overrides a simultaneous Active
      rst = 1'b1; act = 1'b1; din = 1'b1;
      tick();
      tick();
      check("reset_def_outputs", {29'd0, busy_o[0], valid_o[0], crc_o[0]}, 32'd0);
      rst = 1'b0; act = 1'b0; din = 1'b0;
      tick();

      // One-bit frames and a two-bit frame
      frame(32'h0, 1, 10);
      check("one_bit_d0_value", cap[0], 32'h6C);
      check("one_bit_d0_len", cpos[0], 32'd8);
      check("one_bit_d0_fxff", cap[1], 32'h93);
      frame(32'h1, 1, 10);
      check("one_bit_d1_value", cap[0], 32'hA8);
      frame(32'h1, 2, 10);
      check("two_bit_10_value", cap[0], 32'h54);

      // Eight zero bits with SEED=0, first CRC bit right after the last message bit
      for (int k = 0; k < 8; k++) begin
         act = 1'b1; din = 1'b0;
         tick();
      end
      check("s0_no_valid_during_msg", {31'd0, valid_o[2]}, 32'd0);
      act = 1'b0;
      tick();
      check("s0_latency_valid", {31'd0, valid_o[2]}, 32'd1);
      repeat (9) tick();
      check("s0_zero_value", cap[2], 32'h00);
      check("s0_zero_len", cpos[2], 32'd8);

      // Back-to-back frames; Active/DATA toggle randomly while in OUT
      act = 1'b1; din = 1'b0;
      tick();
      act = 1'b0;
      tick();
      for (int k = 0; k < 7; k++) begin
         act = 1'($urandom_range(0, 1));
         din = 1'($urandom_range(0, 1));
         tick();
      end
      check("b2b_first_value", cap[0], 32'h6C);
      act = 1'b1; din = 1'b1;
      tick();
      check("b2b_restart_busy", {30'd0, busy_o[0], valid_o[0]}, 32'd2);
      act = 1'b0; din = 1'b0;
      repeat (10) tick();
      check("b2b_second_value", cap[0], 32'hA8);
      check("b2b_second_len", cpos[0], 32'd8);

      // Reset during OUT bit 3, with Active on the same edge
      act = 1'b1; din = 1'b0;
      tick();
      act = 1'b0;
      repeat (4) tick();
      check("pre_abort_valid", {31'd0, valid_o[0]}, 32'd1);
      rst = 1'b1; act = 1'b1; din = 1'b1;
      tick();
      check("abort_outputs", {29'd0, busy_o[0], valid_o[0], crc_o[0]}, 32'd0);
      rst = 1'b0; act = 1'b0; din = 1'b0;
      repeat (3) tick();
      frame(32'h0, 1, 10);
      check("post_abort_value", cap[0], 32'h6C);

      // Randomized frames with occasional resets
      for (int s = 0; s < 60; s++) begin
         int run;
         int gap;
         run = $urandom_range(1, 24);
         gap = $urandom_range(1, 12);
         for (int r = 0; r < run; r++) begin
            act = 1'b1;
            din = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            tick();
         end
         rst = 1'b0; act = 1'b0; din = 1'b0;
         repeat (gap) tick();
      end
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
